// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
// sel_t encodes the instruction field to extract; codes 5..7 are illegal.
// The *W constants give the width of each immediate field in bits.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    Imm5    = 3'd0,
    Off6    = 3'd1,
    PcOff9  = 3'd2,
    PcOff11 = 3'd3,
    Trap8   = 3'd4
  } sel_t;

  localparam int unsigned Imm5W    = 5;
  localparam int unsigned Off6W    = 6;
  localparam int unsigned PcOff9W  = 9;
  localparam int unsigned PcOff11W = 11;
  localparam int unsigned Trap8W   = 8;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle for imm_ext_pipe.
//   in_valid/in_ready   : request handshake
//   IR, sel, zext, shl  : instruction word, field select, extension mode, shift-by-one
//   out_valid/out_ready : response handshake
//   ext_out, ext_err    : extended result and illegal-select flag at the buffer head
//   occupancy           : number of buffered results
// master = requester/consumer side, slave = the pipeline.
interface imm_ext_pipe_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] IR;
  logic [2:0]        sel;
  logic              zext;
  logic              shl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ext_out;
  logic              ext_err;
  logic [OccW-1:0]   occupancy;

  modport master (
    output in_valid, IR, sel, zext, shl, out_ready,
    input  in_ready, out_valid, ext_out, ext_err, occupancy
  );

  modport slave (
    input  in_valid, IR, sel, zext, shl, out_ready,
    output in_ready, out_valid, ext_out, ext_err, occupancy
  );
endinterface

// File: rtl/ext_fifo.sv
// Strict FIFO of Depth entries, Width bits each (Depth a power of two).
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i/data_i : write an entry (caller guarantees !full_o)
//   pop_i         : drop the head entry (caller guarantees !empty_o)
//   data_o        : head entry, forced to zero while empty
//   full_o, empty_o, count_o : status from the registered count
module ext_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + AddrW'(1);
      end
      if (pop_i) begin
        rptr_q <= rptr_q + AddrW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  // Masking hides stale storage so the head reads zero after reset.
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-field extractor/extender with a buffered valid/ready output.
//   Clk, Reset_n : clock, synchronous active-low reset
//   bus          : imm_ext_pipe_if slave (request, response, occupancy)
// Each accepted request picks an IR field by sel, sign- or zero-extends it to
// DATA_W (TRAP8 always zero-extends), optionally shifts left by one, and
// queues {err, result}. Illegal sel queues zero with err set.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic           Clk,
  input  logic           Reset_n,
  imm_ext_pipe_if.slave  bus
);

  logic [DATA_W-1:0] mask, field, ext, res;
  logic              legal, msb, do_sign, err;
  int unsigned       fw;
  logic              push, pop, full, empty;
  logic [DATA_W:0]   head;

  always_comb begin
    legal = 1'b1;
    fw    = Imm5W;
    case (bus.sel)
      Imm5:    fw = Imm5W;
      Off6:    fw = Off6W;
      PcOff9:  fw = PcOff9W;
      PcOff11: fw = PcOff11W;
      Trap8:   fw = Trap8W;
      default: legal = 1'b0;
    endcase

    mask    = (DATA_W'(1) << fw) - DATA_W'(1);
    field   = bus.IR & mask;
    msb     = |(bus.IR & (DATA_W'(1) << (fw - 1)));
    do_sign = !bus.zext && (bus.sel != Trap8);
    ext     = (do_sign && msb) ? (field | ~mask) : field;
    res     = bus.shl ? {ext[DATA_W-2:0], 1'b0} : ext;
    err     = 1'b0;
    if (!legal) begin
      res = '0;
      err = 1'b1;
    end
  end

  // in_ready comes from the registered count only, so a pop at a full edge
  // frees the slot for the following cycle.
  assign push = bus.in_valid && !full;
  assign pop  = bus.out_ready && !empty;

  ext_fifo #(
    .Width (DATA_W + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .push_i  (push),
    .data_i  ({err, res}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (bus.occupancy)
  );

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.ext_out   = head[DATA_W-1:0];
  assign bus.ext_err   = head[DATA_W];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe (DATA_W=16, DEPTH=2): directed vectors
// with hand-computed results, backpressure, push/pop streaming and reset flush.
module tb_imm_ext_pipe;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_ext_pipe_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  imm_ext_pipe #(.DATA_W(DW), .DEPTH(DP)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  sel;
    logic        zext;
    logic        shl;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } resp_t;

  vec_t  vecs [16];
  resp_t sb_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h err %0b, expected nothing at %0t",
                   bus.ext_out, bus.ext_err, $time);
        end else begin
          e = sb_q.pop_front();
          check("ext_out", 32'(bus.ext_out), 32'(e.data));
          check("ext_err", 32'(bus.ext_err), 32'(e.err));
        end
      end
    end
  end

  task automatic drive(input int i);
    bus.in_valid = 1'b1;
    bus.IR       = vecs[i].ir;
    bus.sel      = vecs[i].sel;
    bus.zext     = vecs[i].zext;
    bus.shl      = vecs[i].shl;
  endtask

  // Waits for acceptance; waited counts cycles in_ready was low.
  task automatic wait_accept(input int i, output int waited);
    bit done = 1'b0;
    resp_t r;
    waited = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        r.data = vecs[i].exp;
        r.err  = vecs[i].err;
        sb_q.push_back(r);
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for 20 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push(input int i);
    int w;
    drive(i);
    wait_accept(i, w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0]  = '{16'h001F, 3'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0};
    vecs[1]  = '{16'h00FF, 3'd4, 1'b0, 1'b1, 16'h01FE, 1'b0};
    vecs[2]  = '{16'h0400, 3'd3, 1'b0, 1'b1, 16'hF800, 1'b0};
    vecs[3]  = '{16'h1234, 3'd6, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4]  = '{16'h001F, 3'd0, 1'b1, 1'b0, 16'h001F, 1'b0};
    vecs[5]  = '{16'h0010, 3'd0, 1'b0, 1'b1, 16'hFFE0, 1'b0};
    vecs[6]  = '{16'h0020, 3'd1, 1'b0, 1'b0, 16'hFFE0, 1'b0};
    vecs[7]  = '{16'h003F, 3'd1, 1'b1, 1'b1, 16'h007E, 1'b0};
    vecs[8]  = '{16'h0100, 3'd2, 1'b0, 1'b0, 16'hFF00, 1'b0};
    vecs[9]  = '{16'hFEFF, 3'd2, 1'b0, 1'b0, 16'h00FF, 1'b0};
    vecs[10] = '{16'h0080, 3'd4, 1'b0, 1'b0, 16'h0080, 1'b0};
    vecs[11] = '{16'h07FF, 3'd3, 1'b1, 1'b0, 16'h07FF, 1'b0};
    vecs[12] = '{16'hABCD, 3'd7, 1'b1, 1'b1, 16'h0000, 1'b1};
    vecs[13] = '{16'hFFFF, 3'd5, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[14] = '{16'hFFFF, 3'd0, 1'b0, 1'b1, 16'hFFFE, 1'b0};
    vecs[15] = '{16'h0200, 3'd2, 1'b0, 1'b0, 16'h0000, 1'b0};

    bus.in_valid  = 1'b0;
    bus.IR        = '0;
    bus.sel       = '0;
    bus.zext      = 1'b0;
    bus.shl       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick(2);

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_ext_out",   32'(bus.ext_out),   32'd0);
    check("rst_ext_err",   32'(bus.ext_err),   32'd0);
    rst_n = 1'b1;
    tick(1);

    // Streaming all vectors; first one also checks single-edge latency.
    bus.out_ready = 1'b1;
    drive(0);
    wait_accept(0, w);
    check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    check("latency_ext_out",   32'(bus.ext_out),   32'hFFFF);
    for (int i = 1; i < 16; i++) push(i);
    tick(4);
    check("stream_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure: fill, hold a third request, then drain.
    bus.out_ready = 1'b0;
    push(0);
    push(1);
    check("full_occupancy", 32'(bus.occupancy), 32'd2);
    check("full_in_ready",  32'(bus.in_ready),  32'd0);
    drive(2);
    repeat (3) begin
      @(negedge clk);
      check("held_in_ready",  32'(bus.in_ready),  32'd0);
      check("held_occupancy", 32'(bus.occupancy), 32'd2);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_accept(2, w);
    check("third_wait_cycles", 32'(w), 32'd1);
    tick(4);
    check("bp_drained", 32'(sb_q.size()), 32'd0);

    // Simultaneous push and pop at occupancy 1.
    bus.out_ready = 1'b0;
    push(3);
    check("one_occupancy", 32'(bus.occupancy), 32'd1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push((k + 4) % 16);
      check("pushpop_occupancy", 32'(bus.occupancy), 32'd1);
    end
    tick(3);
    check("pushpop_drained", 32'(sb_q.size()), 32'd0);

    // Reset with two entries buffered and a request pending.
    bus.out_ready = 1'b0;
    push(5);
    push(6);
    check("pre_rst_occupancy", 32'(bus.occupancy), 32'd2);
    drive(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    sb_q.delete();
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_rst_ext_out",   32'(bus.ext_out),   32'd0);
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_out_valid", 32'(bus.out_valid), 32'd0);
    end
    tick(1);
    push(8);
    tick(3);
    check("final_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 16, datapath and result width; legal values 12..32.
REQ-002 Parameter DEPTH, default 2, output buffer entries; legal values 2..8, power of two.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset; one clock, sampled on the rising edge of Clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 IR  input  DATA_W  instruction word holding the immediate field.
REQ-008 sel  input  3  field select: 0 IMM5, 1 OFF6, 2 PCOFF9, 3 PCOFF11, 4 TRAP8, 5-7 illegal.
REQ-009 zext  input  1  1 = zero-extend, 0 = sign-extend.
REQ-010 shl  input  1  1 = shift extended result left by one.
REQ-011 out_valid  output  1  result present at head of buffer.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 ext_out  output  DATA_W  extended result at buffer head.
REQ-014 ext_err  output  1  head entry came from an illegal sel.
REQ-015 occupancy  output  $clog2(DEPTH)+1  entries currently held.

Function
REQ-016 Field extraction: IMM5=IR[4:0], OFF6=IR[5:0], PCOFF9=IR[8:0], PCOFF11=IR[10:0], TRAP8=IR[7:0].
REQ-017 Sign extension replicates the field MSB into all upper bits up to DATA_W; zero extension fills zeros.
REQ-018 TRAP8 is always zero-extended regardless of zext.
REQ-019 shl=1 shifts the extended value left by one within DATA_W; bit DATA_W-1 is discarded and bit 0 is 0.
REQ-020 Illegal sel yields result 0 with ext_err=1; legal sel yields ext_err=0.
REQ-021 A request is accepted on a rising edge where in_valid && in_ready; result, err are computed from IR/sel/zext/shl of that cycle and pushed into the buffer.
REQ-022 Latency: result accepted at edge N is visible on ext_out with out_valid=1 after edge N when buffer was empty.
REQ-023 Buffer is strict FIFO; an entry is popped on a rising edge where out_valid && out_ready.
REQ-024 in_ready = (occupancy < DEPTH), derived from registered occupancy only; never depends on in_valid.
REQ-025 out_valid = (occupancy != 0); ext_out and ext_err hold stable while out_valid && !out_ready.
REQ-026 Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, order preserved.
REQ-027 Full (occupancy=DEPTH): in_ready=0, no push; a pop that edge frees one slot for the next cycle only.
REQ-028 Empty: pop is impossible (out_valid=0); push into empty buffer makes occupancy 1.
REQ-029 Read/write pointers wrap modulo DEPTH without bubbles.

Reset
REQ-030 Reset_n=0 at an edge clears pointers and occupancy to 0; out_valid=0, ext_out=0, ext_err=0, in_ready=1 after that edge.
REQ-031 Reset mid-operation discards all buffered entries; a request presented during reset is not accepted.

Structure
REQ-032 Package imm_ext_pkg holds enum sel_t (IMM5, OFF6, PCOFF9, PCOFF11, TRAP8) and field-width constants 5, 6, 9, 11, 8.
REQ-033 Buffer is one sub-module ext_fifo (parametrised DATA_W+1 wide, DEPTH deep); extraction/extension logic stays in imm_ext_pipe.

Verification
REQ-034 DATA_W=16, IR=16'h001F, sel=IMM5, zext=0, shl=0 -> next cycle ext_out=16'hFFFF, ext_err=0.
REQ-035 IR=16'h00FF, sel=TRAP8, zext=0, shl=1 -> ext_out=16'h01FE; IR=16'h0400, sel=PCOFF11, zext=0, shl=1 -> 16'hF800.
REQ-036 sel=6 any IR -> ext_out=16'h0000, ext_err=1.
REQ-037 DEPTH=2, out_ready=0, push 3 requests -> occupancy 2, in_ready=0 after second; third held; out_ready=1 drains in push order, third accepted on next cycle.
REQ-038 occupancy=1, push and pop same edge for 10 cycles -> occupancy stays 1, results in order, no loss.
REQ-039 occupancy=2, Reset_n=0 one edge -> out_valid=0, occupancy=0, in_ready=1; prior entries never appear.
